// File: rtl/opcodes.sv
// Shared opcode definitions: branch condition selector and the status-flag bit
// positions used by the ALU and the register file.
package opcodes;

  typedef enum logic [2:0] {
    ALWAYS = 3'd0,
    NEVER  = 3'd1,
    EQ     = 3'd2,
    NE     = 3'd3,
    CS     = 3'd4,
    CC     = 3'd5,
    LT     = 3'd6,
    GE     = 3'd7
  } cond_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from the registered status flags.
module cond_eval
  import opcodes::*;
(
  input  logic [3:0] StatusFlags,
  input  cond_t      Cond,
  output logic       Taken
);

  logic z;
  logic c;
  logic v;
  logic n;

  assign z = StatusFlags[FLAG_Z];
  assign c = StatusFlags[FLAG_C];
  assign v = StatusFlags[FLAG_V];
  assign n = StatusFlags[FLAG_N];

  // Signed less-than is N xor V; the default arm keeps Taken low for any
  // encoding outside the defined set.
  always_comb begin
    Taken = 1'b0;
    case (Cond)
      ALWAYS:  Taken = 1'b1;
      NEVER:   Taken = 1'b0;
      EQ:      Taken = z;
      NE:      Taken = ~z;
      CS:      Taken = c;
      CC:      Taken = ~c;
      LT:      Taken = n ^ v;
      GE:      Taken = ~(n ^ v);
      default: Taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/regfile_flags.sv
// General register file with write-through bypass, plus the status flag
// register and branch-condition evaluation.
module regfile_flags
  import opcodes::*;
#(
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [15:0]   Op1,
  output logic [15:0]   Op2,
  input  logic [AW-1:0] Rw,
  input  logic [15:0]   WData,
  input  logic          WE,
  input  logic [3:0]    AluFlags,
  input  logic          FlagsEn,
  input  cond_t         Cond,
  output logic          Taken,
  output logic [3:0]    StatusFlags
);

  logic [15:0] regs [NREGS];
  logic        write_live;

  // Reset wins over a same-cycle write; registers are plain flops.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (WE) begin
      regs[Rw] <= WData;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      StatusFlags <= 4'b0000;
    end else if (FlagsEn) begin
      StatusFlags <= AluFlags;
    end
  end

  // A write that reset will discard must never appear on the read ports.
  assign write_live = WE & nReset;

  assign Op1 = (write_live && (Rw == Ra)) ? WData : regs[Ra];
  assign Op2 = (write_live && (Rw == Rb)) ? WData : regs[Rb];

  cond_eval u_cond_eval (
    .StatusFlags (StatusFlags),
    .Cond        (Cond),
    .Taken       (Taken)
  );

endmodule

// File: tb/tb_regfile_flags.sv
// Self-checking bench for regfile_flags: a table of per-cycle directed vectors
// plus hand-written sequences for reset, single-write scan and full pair readback.
module tb_regfile_flags;
  import opcodes::*;

  localparam int NREGS = 8;

  logic        clock;
  logic        nReset;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  rw;
  logic [15:0] wData;
  logic        we;
  logic [3:0]  aluFlags;
  logic        flagsEn;
  cond_t       cond;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        taken;
  logic [3:0]  statusFlags;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        nrst;
    logic        we;
    logic [2:0]  rw;
    logic [15:0] wdata;
    logic        fe;
    logic [3:0]  af;
    logic [2:0]  ra;
    logic [2:0]  rb;
    cond_t       cond;
    logic [15:0] expOp1;
    logic [15:0] expOp2;
    logic        expTaken;
    logic [3:0]  expStatus;
  } vec_t;

  vec_t vecs[$];

  regfile_flags #(.NREGS(NREGS)) dut (
    .Clock       (clock),
    .nReset      (nReset),
    .Ra          (ra),
    .Rb          (rb),
    .Op1         (op1),
    .Op2         (op2),
    .Rw          (rw),
    .WData       (wData),
    .WE          (we),
    .AluFlags    (aluFlags),
    .FlagsEn     (flagsEn),
    .Cond        (cond),
    .Taken       (taken),
    .StatusFlags (statusFlags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void addVec(input logic nrst, input logic wen, input logic [2:0] wadr,
                                 input logic [15:0] wd, input logic fe, input logic [3:0] af,
                                 input logic [2:0] a, input logic [2:0] b, input cond_t c,
                                 input logic [15:0] e1, input logic [15:0] e2,
                                 input logic et, input logic [3:0] es);
    vec_t v;
    v.nrst = nrst; v.we = wen; v.rw = wadr; v.wdata = wd; v.fe = fe; v.af = af;
    v.ra = a; v.rb = b; v.cond = c;
    v.expOp1 = e1; v.expOp2 = e2; v.expTaken = et; v.expStatus = es;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    nReset   = v.nrst;
    we       = v.we;
    rw       = v.rw;
    wData    = v.wdata;
    flagsEn  = v.fe;
    aluFlags = v.af;
    ra       = v.ra;
    rb       = v.rb;
    cond     = v.cond;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    // Idle inputs, then two reset cycles so the array leaves X.
    nReset = 1'b0; we = 1'b0; rw = '0; wData = '0; flagsEn = 1'b0;
    aluFlags = '0; ra = '0; rb = '0; cond = ALWAYS;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    checkOutput("reset.status", {12'h0, statusFlags}, 16'h0);
    checkOutput("reset.op1", op1, 16'h0);

    // Write R3 = BEEF, then scan every register.
    nReset = 1'b1; we = 1'b1; rw = 3'd3; wData = 16'hBEEF;
    @(negedge clock);
    we = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      ra = 3'(i);
      #1;
      checkOutput($sformatf("scan.r%0d", i), op1, (i == 3) ? 16'hBEEF : 16'h0000);
    end

    //      nrst we rw    wdata    fe af       ra    rb    cond    op1      op2      tk  status
    addVec(1'b0, 1, 3'd2, 16'hFFFF, 1, 4'hF,    3'd2, 3'd3, ALWAYS, 16'h0000, 16'hBEEF, 1, 4'h0);
    addVec(1'b1, 1, 3'd3, 16'hBEEF, 0, 4'h0,    3'd2, 3'd0, NEVER,  16'h0000, 16'h0000, 0, 4'h0);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd3, 3'd4, EQ,     16'hBEEF, 16'h0000, 0, 4'h0);
    addVec(1'b1, 1, 3'd5, 16'h1234, 1, 4'b0001, 3'd5, 3'd5, NE,     16'h1234, 16'h1234, 1, 4'h0);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd5, 3'd3, EQ,     16'h1234, 16'hBEEF, 1, 4'b0001);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd0, 3'd1, NE,     16'h0000, 16'h0000, 0, 4'b0001);
    addVec(1'b1, 1, 3'd0, 16'h0A0A, 1, 4'b1000, 3'd0, 3'd7, EQ,     16'h0A0A, 16'h0000, 1, 4'b0001);
    addVec(1'b1, 0, 3'd0, 16'h0000, 1, 4'b1100, 3'd0, 3'd5, LT,     16'h0A0A, 16'h1234, 1, 4'b1000);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd3, 3'd2, GE,     16'hBEEF, 16'h0000, 1, 4'b1100);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd3, 3'd2, LT,     16'hBEEF, 16'h0000, 0, 4'b1100);
    addVec(1'b1, 0, 3'd0, 16'h0000, 1, 4'b0010, 3'd3, 3'd2, CS,     16'hBEEF, 16'h0000, 0, 4'b1100);
    addVec(1'b0, 1, 3'd5, 16'hFFFF, 1, 4'h0,    3'd5, 3'd3, CS,     16'h1234, 16'hBEEF, 1, 4'b0010);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd5, 3'd3, CC,     16'h0000, 16'h0000, 1, 4'h0);
    addVec(1'b1, 1, 3'd7, 16'h5A5A, 0, 4'h0,    3'd6, 3'd7, ALWAYS, 16'h0000, 16'h5A5A, 1, 4'h0);
    addVec(1'b1, 0, 3'd0, 16'h0000, 0, 4'h0,    3'd7, 3'd7, NEVER,  16'h5A5A, 16'h5A5A, 0, 4'h0);

    foreach (vecs[k]) begin
      @(negedge clock);
      applyStimulus(vecs[k]);
      #2;
      checkOutput($sformatf("v%0d.op1", k), op1, vecs[k].expOp1);
      checkOutput($sformatf("v%0d.op2", k), op2, vecs[k].expOp2);
      checkOutput($sformatf("v%0d.taken", k), {15'h0, taken}, {15'h0, vecs[k].expTaken});
      checkOutput($sformatf("v%0d.status", k), {12'h0, statusFlags}, {12'h0, vecs[k].expStatus});
    end

    // Fill every register with index+0x100, then read back all address pairs.
    @(negedge clock);
    nReset = 1'b1; flagsEn = 1'b0; we = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      rw = 3'(i);
      wData = 16'h0100 + 16'(i);
      @(negedge clock);
    end
    we = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      for (int j = 0; j < NREGS; j++) begin
        ra = 3'(i);
        rb = 3'(j);
        #1;
        checkOutput($sformatf("pair.op1[%0d]", i), op1, 16'h0100 + 16'(i));
        checkOutput($sformatf("pair.op2[%0d]", j), op2, 16'h0100 + 16'(j));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
